// File: rtl/vga_sync_generator_pkg.sv
// Shared raster timing definitions: default 640x480@60 constants, totals and axis states.
package video_timing_pkg;

    function automatic int axis_total(int active, int front, int sync, int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CW       = 10;

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef enum logic [1:0] {
        AX_ACTIVE = 2'd0,
        AX_FRONT  = 2'd1,
        AX_SYNC   = 2'd2,
        AX_BACK   = 2'd3
    } axis_state_e;

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster output bundle: syncs, active-video qualifier, frame marker and coordinates.
interface vga_sync_generator_if #(parameter int CW = 10);
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          frame_end;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;

    modport master (output hsync, vsync, video_on, frame_end, pixel_x, pixel_y);
    modport slave  (input  hsync, vsync, video_on, frame_end, pixel_x, pixel_y);
endinterface

// File: rtl/vga_sync_generator_sync_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region tracker.
module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE   = DEF_H_ACTIVE,
    parameter int FRONT    = DEF_H_FRONT,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BACK     = DEF_H_BACK,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          active,
    output logic          last
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] END_FRONT  = CW'(ACTIVE + FRONT - 1);
    localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CW-1:0] END_BACK   = CW'(TOTAL - 1);

    axis_state_e   state, state_n;
    logic [CW-1:0] count_n;
    logic          sync_n;
    logic          active_n;

    // Decoded straight from the count register so it lines up with count in the same cycle.
    assign last = (count == END_BACK);

    always_comb begin
        state_n = state;
        count_n = count;
        if (advance) begin
            count_n = last ? '0 : count + 1'b1;
            case (state)
                AX_ACTIVE: if (count == END_ACTIVE) state_n = AX_FRONT;
                AX_FRONT:  if (count == END_FRONT)  state_n = AX_SYNC;
                AX_SYNC:   if (count == END_SYNC)   state_n = AX_BACK;
                AX_BACK:   if (count == END_BACK)   state_n = AX_ACTIVE;
                default:   state_n = AX_BACK;
            endcase
        end
        active_n = (state_n == AX_ACTIVE);
        sync_n   = (state_n == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= AX_BACK;
            count  <= END_BACK;
            sync   <= ~SYNC_POL;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            sync   <= sync_n;
            active <= active_n;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// Raster timing generator: horizontal and vertical axis counters combined into VGA outputs.
module vga_sync_generator
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic                clk,
    input  logic                reset,
    vga_sync_generator_if.master vga
);

    logic [CW-1:0] h_count, v_count;
    logic          h_sync, v_sync;
    logic          h_active, v_active;
    logic          h_last, v_last;
    logic          running;

    sync_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .SYNC_POL(SYNC_POL), .CW(CW)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .advance(1'b1),
        .count  (h_count),
        .sync   (h_sync),
        .active (h_active),
        .last   (h_last)
    );

    sync_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .SYNC_POL(SYNC_POL), .CW(CW)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .advance(h_last),
        .count  (v_count),
        .sync   (v_sync),
        .active (v_active),
        .last   (v_last)
    );

    // Both counters sit at their maximum while in reset; this keeps frame_end quiet there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) running <= 1'b0;
        else        running <= 1'b1;
    end

    assign vga.pixel_x   = h_count;
    assign vga.pixel_y   = v_count;
    assign vga.hsync     = h_sync;
    assign vga.vsync     = v_sync;
    assign vga.video_on  = h_active & v_active;
    assign vga.frame_end = h_last & v_last & running;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Three generator instances (default, medium, tiny active-high) against an arithmetic raster model.
module tb_vga_sync_generator;

    localparam int ND = 3;
    localparam int HA [ND] = '{640, 16, 4};
    localparam int HF [ND] = '{16, 2, 1};
    localparam int HS [ND] = '{96, 3, 2};
    localparam int HB [ND] = '{48, 3, 1};
    localparam int VA [ND] = '{480, 12, 3};
    localparam int VF [ND] = '{10, 2, 1};
    localparam int VS [ND] = '{2, 2, 1};
    localparam int VB [ND] = '{33, 2, 1};
    localparam bit POL [ND] = '{1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       fe;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic       clk = 1'b0;
    logic [2:0] rst;
    obs_t       act [ND];
    int         n_chk = 0;
    int         n_fail = 0;
    int         k [ND];
    int         hrun [ND];
    int         vrun [ND];
    int         fe_k [ND];

    always #5 clk = ~clk;

    vga_sync_generator_if #(.CW(10)) vif0 ();
    vga_sync_generator_if #(.CW(10)) vif1 ();
    vga_sync_generator_if #(.CW(10)) vif2 ();

    vga_sync_generator #(
        .H_ACTIVE(HA[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
        .V_ACTIVE(VA[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
        .SYNC_POL(POL[0]), .CW(10)
    ) u_dut0 (.clk(clk), .reset(rst[0]), .vga(vif0));

    vga_sync_generator #(
        .H_ACTIVE(HA[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
        .V_ACTIVE(VA[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
        .SYNC_POL(POL[1]), .CW(10)
    ) u_dut1 (.clk(clk), .reset(rst[1]), .vga(vif1));

    vga_sync_generator #(
        .H_ACTIVE(HA[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
        .V_ACTIVE(VA[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
        .SYNC_POL(POL[2]), .CW(10)
    ) u_dut2 (.clk(clk), .reset(rst[2]), .vga(vif2));

    assign act[0] = {vif0.hsync, vif0.vsync, vif0.video_on, vif0.frame_end, vif0.pixel_x, vif0.pixel_y};
    assign act[1] = {vif1.hsync, vif1.vsync, vif1.video_on, vif1.frame_end, vif1.pixel_x, vif1.pixel_y};
    assign act[2] = {vif2.hsync, vif2.vsync, vif2.video_on, vif2.frame_end, vif2.pixel_x, vif2.pixel_y};

    function automatic int ht(int d);
        return HA[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vt(int d);
        return VA[d] + VF[d] + VS[d] + VB[d];
    endfunction

    // kk = rising edges seen since reset release; 0 means the reset state.
    function automatic obs_t model(int d, int kk);
        obs_t m;
        int   x, y, p;
        if (kk == 0) begin
            x = ht(d) - 1;
            y = vt(d) - 1;
        end else begin
            p = (kk - 1) % (ht(d) * vt(d));
            x = p % ht(d);
            y = p / ht(d);
        end
        m.x   = 10'(x);
        m.y   = 10'(y);
        m.hs  = (x >= HA[d] + HF[d] && x < HA[d] + HF[d] + HS[d]) ? POL[d] : ~POL[d];
        m.vs  = (y >= VA[d] + VF[d] && y < VA[d] + VF[d] + VS[d]) ? POL[d] : ~POL[d];
        m.von = (x < HA[d]) && (y < VA[d]);
        m.fe  = (kk != 0) && (x == ht(d) - 1) && (y == vt(d) - 1);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t g, input obs_t e);
        chk({tag, ".x"},   32'(g.x),   32'(e.x));
        chk({tag, ".y"},   32'(g.y),   32'(e.y));
        chk({tag, ".hs"},  32'(g.hs),  32'(e.hs));
        chk({tag, ".vs"},  32'(g.vs),  32'(e.vs));
        chk({tag, ".von"}, 32'(g.von), 32'(e.von));
        chk({tag, ".fe"},  32'(g.fe),  32'(e.fe));
    endtask

    // Reset is asserted between edges and checked before the next rising edge arrives.
    task automatic pulse_rst(input int d, input int hold);
        @(posedge clk);
        #2;
        rst[d] = 1'b0;
        #1;
        chk_obs($sformatf("async%0d", d), act[d], model(d, 0));
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1;
        rst[d] = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst[d]) begin
                k[d]    = 0;
                hrun[d] = 0;
                vrun[d] = 0;
                fe_k[d] = 0;
            end else begin
                k[d]++;
            end
            chk_obs($sformatf("d%0d", d), act[d], model(d, k[d]));
            if (rst[d]) begin
                if (act[d].hs == POL[d]) hrun[d]++;
                else if (hrun[d] != 0) begin
                    chk($sformatf("d%0d.hsync_len", d), 32'(hrun[d]), 32'(HS[d]));
                    hrun[d] = 0;
                end
                if (act[d].vs == POL[d]) vrun[d]++;
                else if (vrun[d] != 0) begin
                    chk($sformatf("d%0d.vsync_len", d), 32'(vrun[d]), 32'(VS[d] * ht(d)));
                    vrun[d] = 0;
                end
                if (act[d].fe) begin
                    if (fe_k[d] != 0)
                        chk($sformatf("d%0d.fe_gap", d), 32'(k[d] - fe_k[d]), 32'(ht(d) * vt(d)));
                    fe_k[d] = k[d];
                end
            end
        end
    end

    initial begin
        rst = '1;
        #1;
        rst = '0;
        #2;
        for (int d = 0; d < ND; d++) chk_obs($sformatf("por%0d", d), act[d], model(d, 0));
        repeat (2) @(negedge clk);
        #1;
        rst = '1;
        repeat (1800) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            int w, d, h;
            w = $urandom_range(20, 400);
            d = $urandom_range(0, ND - 1);
            h = $urandom_range(1, 4);
            repeat (w) @(posedge clk);
            pulse_rst(d, h);
        end
        repeat (1000) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Raster timing generator for the video output path. It runs on the divided pixel clock (25 MHz for 640x480@60 from a divide-by-2 of 50 MHz) and produces horizontal/vertical sync, the active-video qualifier, and the current pixel coordinates. Downstream, the sprite/background pixel logic reads these coordinates, and the DAC/VGA pins take the sync outputs. All outputs are registered and mutually coherent in every cycle.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
- CW, 10, coordinate counter width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  pixel clock. Single clock domain; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hsync  out  1  horizontal sync at SYNC_POL level during the sync interval
- vsync  out  1  vertical sync at SYNC_POL level during the sync lines
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- pixel_x  out  CW  current horizontal position, 0..H_TOTAL-1
- pixel_y  out  CW  current vertical position, 0..V_TOTAL-1
- frame_end  out  1  one-cycle pulse at the last pixel of a frame

## Operation

- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is defined the same way.
- Each axis walks the states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. State changes when the axis count reaches the last position of the current region.
- Horizontal count increments every cycle and wraps from H_TOTAL-1 to 0.
- Vertical count increments only on the horizontal wrap cycle. It wraps from V_TOTAL-1 to 0 on the same edge in which both counts are at their maximum.
- Sync windows:
  - hsync is asserted for pixel_x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - vsync is asserted for pixel_y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], across the full line width.
- Outputs are registered from next-state values. In any cycle, hsync, vsync, video_on and frame_end correspond exactly to the pixel_x and pixel_y presented in that same cycle.
- frame_end is high exactly when (pixel_x, pixel_y) = (H_TOTAL-1, V_TOTAL-1). The only exception is the reset state, where it is held at 0.
- Counter arithmetic is unsigned, CW bits wide. Comparisons use the constants derived from the parameters, with no off-by-one slack.

## Timing

- Reset asserted, taking effect immediately and asynchronously:
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1
  - video_on = 0, frame_end = 0
  - hsync and vsync at the deasserted level (~SYNC_POL)
  - Both axes are in the BACK state.
- First rising edge after reset release: (0,0), video_on = 1, both syncs deasserted.
- Latency from counter to outputs: 0 cycles. There is no pipeline skew between coordinates and qualifiers.
- Reset asserted mid-frame: outputs return to the reset values within the same cycle. No partial sync pulse is extended.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles (420000 at default parameters).
- Simultaneous horizontal and vertical wrap: both counts go to 0 on the same edge, and frame_end drops on that edge.

## Structure

- Shared package `video_timing_pkg` holds:
  - the default 640x480@60 timing constants
  - the H_TOTAL and V_TOTAL derivations
  - the axis state encoding (ACTIVE, FRONT, SYNC, BACK)
- Natural sub-module: `sync_axis_counter`, instantiated twice (horizontal and vertical).
  - Inputs: clk, reset, advance.
  - Outputs: count, sync, active, last.
  - The horizontal instance has advance tied high. The vertical instance's advance is the horizontal `last`.
- The top level combines `active` from both axes into video_on, and both `last` outputs into frame_end.

## Test plan

- Reset release with default parameters -> first edge gives pixel_x = 0, pixel_y = 0, video_on = 1. pixel_x reaches 639 after 639 further cycles; video_on drops at pixel_x = 640.
- Run one line -> hsync is low for exactly 96 consecutive cycles, at pixel_x 656..751. pixel_y increments to 1 on the edge where pixel_x wraps 799 -> 0.
- Run one full frame -> vsync is low for exactly 1600 cycles, spanning lines 490..491. video_on is never high for pixel_y >= 480.
- Run two frames -> frame_end pulses for 1 cycle at (799,524). The pulses are exactly 420000 cycles apart.
- Assert reset at (300,200) -> outputs go to (799,524) with video_on = 0, frame_end = 0 and syncs high, without waiting for a clock edge. After release, counting restarts at (0,0).
- Small parameters (H 4/1/2/1, V 3/1/1/1, SYNC_POL = 1) -> hsync is high at pixel_x 5..6, the line period is 8 cycles, and the frame period is 48 cycles.
